tdm_demux_4x1: RTL and testbench
================================

TDM_DEMUX_4X1 -- requirements
Module: tdm_demux_4x1

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per channel sample.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  qualifies in_data/in_sync this cycle; cycles with in_valid=0 are ignored.
REQ-005 SHALL have port in_sync  input  1  marks the current sample as slot 0 of a frame.
REQ-006 SHALL have port in_data  input  WIDTH  time-multiplexed sample stream (slot order 0,1,2,3).
REQ-007 SHALL have port out_0..out_3  output  WIDTH each  last complete frame, one channel per port.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse when out_0..out_3 update.
REQ-009 SHALL have port locked  output  1  high while in LOCK state.
REQ-010 SHALL have port sync_err  output  1  one-cycle pulse on misplaced in_sync.
REQ-011 SHALL have port frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-012 SHALL implement FSM states HUNT and LOCK; reset state HUNT.
REQ-013 In HUNT, SHALL discard samples until in_valid=1 and in_sync=1; that sample SHALL be captured as slot 0, slot counter set to 1, state -> LOCK.
REQ-014 In LOCK, each in_valid=1 sample SHALL be captured into holding register [slot], slot counter +1, wrapping 3->0.
REQ-015 On capturing slot 3, SHALL copy holding regs 0..2 plus the slot-3 sample to out_0..out_3 and pulse out_valid in the cycle after the slot-3 sample (latency 1 clk).
REQ-016 Outputs out_0..out_3 SHALL hold their value between updates; partial frames SHALL never appear on them.
REQ-017 frame_cnt SHALL increment in the same cycle out_valid is asserted.
REQ-018 In LOCK, in_sync=1 with slot counter != 0 SHALL pulse sync_err next cycle, discard the partial frame, capture the sample as slot 0, set counter to 1, remain LOCK.
REQ-019 In LOCK, in_sync=0 at slot 0 SHALL NOT be an error (sync is optional after lock).
REQ-020 in_sync with in_valid=0 SHALL be ignored.
REQ-021 out_valid and sync_err SHALL never assert in the same cycle from the same sample.
REQ-022 Gaps (in_valid=0) of any length SHALL NOT change slot counter or state.

Reset
REQ-023 rst_n=0 SHALL immediately clear out_0..out_3, holding regs, slot counter, frame_cnt to 0, out_valid/sync_err/locked to 0, state HUNT.
REQ-024 Reset mid-frame SHALL discard the partial frame; after release, capture resumes only via HUNT.

Configuration
REQ-025 Macro TDM_DEMUX_PARITY_EN defined: frame SHALL be 5 slots (0..4), slot 4 carrying even parity (XOR of all bits of slots 0..3 plus slot 4 = 0); output update/out_valid SHALL occur after slot 4; port par_err output 1 SHALL pulse with out_valid on parity failure, outputs still updated.
REQ-026 Macro undefined: 4-slot frame, no par_err port, no parity logic.

Verification
REQ-027 Reset, then in_valid=1 stream sync=1 with data 0,1,1,1 (WIDTH=1) -> out_0..3=0,1,1,1, out_valid one cycle after slot 3, locked=1, frame_cnt=1.
REQ-028 Data before first in_sync (1,1,0) then sync frame 1,0,0,0 -> pre-sync samples dropped, outputs 1,0,0,0.
REQ-029 Frame 0,0,1,0 with in_valid=0 gaps of 3 cycles between samples -> same result as gapless, single out_valid.
REQ-030 In LOCK, in_sync at slot 2 -> sync_err pulse, no out_valid, next 4 samples 0,0,0,1 -> outputs 0,0,0,1.
REQ-031 rst_n low after slot 1 of a frame -> all outputs 0 immediately, locked=0; subsequent non-sync samples ignored.
REQ-032 256 consecutive frames -> frame_cnt returns to 0; with TDM_DEMUX_PARITY_EN, wrong parity slot -> par_err pulse with out_valid.

Source files
------------

// File: rtl/tdm_demux_4x1.sv
// tdm_demux_4x1: recovers four channels from a framed TDM sample stream.
// Define TDM_DEMUX_PARITY_EN for a fifth even-parity slot and the par_err port.
module tdm_demux_4x1 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sync,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] out_0,
   output logic [WIDTH-1:0] out_1,
   output logic [WIDTH-1:0] out_2,
   output logic [WIDTH-1:0] out_3,
   output logic             out_valid,
   output logic             locked,
   output logic             sync_err,
   output logic [7:0]       frame_cnt
`ifdef TDM_DEMUX_PARITY_EN
   ,
   output logic             par_err
`endif
);

   typedef enum logic {
      HUNT,
      LOCK
   } state_t;

`ifdef TDM_DEMUX_PARITY_EN
   localparam logic [2:0] LAST_SLOT = 3'd4;
`else
   localparam logic [2:0] LAST_SLOT = 3'd3;
`endif

   state_t           state;
   logic [2:0]       slot;
   logic [WIDTH-1:0] hold [0:3];

   // The final slot of a frame bypasses the holding registers so the whole
   // frame lands on the outputs in one cycle and partial frames never show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         slot      <= '0;
         for (int i = 0; i < 4; i++) hold[i] <= '0;
         out_0     <= '0;
         out_1     <= '0;
         out_2     <= '0;
         out_3     <= '0;
         out_valid <= 1'b0;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
         frame_cnt <= '0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err   <= 1'b0;
`endif
         if (in_valid) begin
            case (state)
               HUNT: begin
                  if (in_sync) begin
                     hold[0] <= in_data;
                     slot    <= 3'd1;
                     state   <= LOCK;
                     locked  <= 1'b1;
                  end
               end
               LOCK: begin
                  if (in_sync && (slot != 3'd0)) begin
                     sync_err <= 1'b1;
                     hold[0]  <= in_data;
                     slot     <= 3'd1;
                  end else if (slot == LAST_SLOT) begin
                     out_0     <= hold[0];
                     out_1     <= hold[1];
                     out_2     <= hold[2];
`ifdef TDM_DEMUX_PARITY_EN
                     out_3     <= hold[3];
                     par_err   <= ^{hold[0], hold[1], hold[2], hold[3], in_data};
`else
                     out_3     <= in_data;
`endif
                     out_valid <= 1'b1;
                     frame_cnt <= frame_cnt + 8'd1;
                     slot      <= 3'd0;
                  end else begin
                     hold[slot[1:0]] <= in_data;
                     slot            <= slot + 3'd1;
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux_4x1.sv
// Directed self-checking bench for tdm_demux_4x1 (WIDTH=1).
// Honours TDM_DEMUX_PARITY_EN by appending the parity slot to every frame.
module tb_tdm_demux_4x1;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_sync;
   logic [0:0] in_data;
   logic [0:0] out_0, out_1, out_2, out_3;
   logic       out_valid;
   logic       locked;
   logic       sync_err;
   logic [7:0] frame_cnt;
`ifdef TDM_DEMUX_PARITY_EN
   logic       par_err;
`endif
   logic [3:0] outs;

   int         error_count;
   int         check_count;
   int         pulse_count;

   tdm_demux_4x1 #(.WIDTH(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sync   (in_sync),
      .in_data   (in_data),
      .out_0     (out_0),
      .out_1     (out_1),
      .out_2     (out_2),
      .out_3     (out_3),
      .out_valid (out_valid),
      .locked    (locked),
      .sync_err  (sync_err),
      .frame_cnt (frame_cnt)
`ifdef TDM_DEMUX_PARITY_EN
      ,
      .par_err   (par_err)
`endif
   );

   assign outs = {out_0, out_1, out_2, out_3};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Presents one cycle of input, then returns just after the capturing edge.
   task automatic applyStimulus(input logic v, input logic s, input logic d);
      @(negedge clk);
      in_valid   = v;
      in_sync    = s;
      in_data[0] = d;
      @(posedge clk);
      #1;
      if (out_valid) pulse_count++;
      in_valid = 1'b0;
      in_sync  = 1'b0;
   endtask

   task automatic sendFrame(input logic s, input logic d0, input logic d1,
                            input logic d2, input logic d3);
      applyStimulus(1'b1, s, d0);
      applyStimulus(1'b1, 1'b0, d1);
      applyStimulus(1'b1, 1'b0, d2);
      applyStimulus(1'b1, 1'b0, d3);
`ifdef TDM_DEMUX_PARITY_EN
      applyStimulus(1'b1, 1'b0, d0 ^ d1 ^ d2 ^ d3);
`endif
   endtask

   task automatic doReset();
      in_valid   = 1'b0;
      in_sync    = 1'b0;
      in_data[0] = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      error_count = 0;
      check_count = 0;
      pulse_count = 0;

      doReset();
      checkOutput("reset_outs", outs, 4'b0000);
      checkOutput("reset_locked", locked, 1'b0);
      checkOutput("reset_frame_cnt", frame_cnt, 8'd0);
      checkOutput("reset_out_valid", out_valid, 1'b0);
      checkOutput("reset_sync_err", sync_err, 1'b0);

      // First locked frame 0,1,1,1
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("lock_after_sync", locked, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
      checkOutput("no_valid_before_parity", out_valid, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("good_parity", par_err, 1'b0);
`endif
      checkOutput("f1_out_valid", out_valid, 1'b1);
      checkOutput("f1_outs", outs, 4'b0111);
      checkOutput("f1_frame_cnt", frame_cnt, 8'd1);
      checkOutput("f1_sync_err", sync_err, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("f1_valid_pulse", out_valid, 1'b0);
      checkOutput("f1_outs_hold", outs, 4'b0111);

      // Pre-sync samples must be dropped
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hunt_not_locked", locked, 1'b0);
      sendFrame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("presync_outs", outs, 4'b1000);
      checkOutput("presync_frame_cnt", frame_cnt, 8'd1);

      // Frame 0,0,1,0 with 3-cycle gaps; sync during gaps is ignored
      pulse_count = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("gap_sync_ignored", sync_err, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("gap_partial_hidden", outs, 4'b1000);
      checkOutput("gap_no_early_valid", out_valid, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
`endif
      checkOutput("gap_outs", outs, 4'b0010);
      checkOutput("gap_single_valid", pulse_count, 1);
      checkOutput("gap_frame_cnt", frame_cnt, 8'd2);

      // Misplaced sync at slot 2 restarts the frame
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("serr_pulse", sync_err, 1'b1);
      checkOutput("serr_no_valid", out_valid, 1'b0);
      checkOutput("serr_locked", locked, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("serr_one_cycle", sync_err, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
`ifdef TDM_DEMUX_PARITY_EN
      applyStimulus(1'b1, 1'b0, 1'b1);
`endif
      checkOutput("serr_out_valid", out_valid, 1'b1);
      checkOutput("serr_outs", outs, 4'b0001);
      checkOutput("serr_frame_cnt", frame_cnt, 8'd3);

      // Asynchronous reset mid-frame
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_outs", outs, 4'b0000);
      checkOutput("async_rst_locked", locked, 1'b0);
      checkOutput("async_rst_frame_cnt", frame_cnt, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse_count = 0;
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("post_rst_hunt", locked, 1'b0);
      checkOutput("post_rst_no_valid", pulse_count, 0);
      checkOutput("post_rst_outs", outs, 4'b0000);

      // 256 frames wrap frame_cnt back to zero
      for (int i = 0; i < 256; i++) begin
         sendFrame(i == 0, i[0], i[1], i[2], i[3]);
         if (i == 254) begin
            checkOutput("wrap_cnt_255", frame_cnt, 8'd255);
            checkOutput("wrap_outs_254", outs, 4'b0111);
         end
         if (i == 255) begin
            checkOutput("wrap_cnt_0", frame_cnt, 8'd0);
            checkOutput("wrap_outs_255", outs, 4'b1111);
         end
      end

`ifdef TDM_DEMUX_PARITY_EN
      // Frame 1,0,1,1 needs parity 1; send 0 instead
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("bad_par_err", par_err, 1'b1);
      checkOutput("bad_par_valid", out_valid, 1'b1);
      checkOutput("bad_par_outs", outs, 4'b1011);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bad_par_pulse", par_err, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

endmodule
